// File: rtl/dm_responder_pkg.sv
// Shared types and helpers for the stalling data-memory responder.
// Contents:
//   dmr_state_t       - responder FSM states
//   DMR_DEPTH_LOG2    - default storage depth (log2 of word count)
//   DMR_LATENCY       - default request-to-response latency in cycles
//   word_out_of_range - word-index bounds check against the storage depth
package dm_responder_pkg;

  localparam int unsigned DMR_DEPTH_LOG2 = 10;
  localparam int unsigned DMR_LATENCY    = 2;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } dmr_state_t;

  // The compare is done on the full 30-bit word index, one bit wider than
  // needed, so that large addresses never alias back into the array.
  function automatic logic word_out_of_range(input logic [29:0] word,
                                             input int unsigned depth_log2);
    return {1'b0, word} >= (31'd1 << depth_log2);
  endfunction

endpackage

// File: rtl/dm_responder_if.sv
// Load/store bus between the Memory-stage initiator and the responder.
// Signals:
//   req_valid/req_ready  request handshake (taken on valid & ready)
//   req_we               1 = store, 0 = load
//   req_addr             byte address, bits [1:0] ignored
//   req_be               store byte enables, one bit per byte lane
//   req_wdata            store data
//   resp_valid/resp_ready response handshake
//   resp_rdata           load data, 0 for stores and errors
//   resp_err             address out of range
// Modports: master (initiator side), slave (responder side).
interface dm_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_be, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_be, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dm_responder_bank.sv
// Word-addressed storage split into four byte-lane arrays.
// Ports:
//   clk, reset   clock and synchronous active-low reset (read register only)
//   clr_en/clr_idx  zero one word per cycle (used by the power-up clear sweep)
//   wr_en/wr_be  byte-lane store into word idx
//   idx, wdata   shared word index and store data
//   rd_en        capture word idx into the read register
//   rd_zero      load 0 into the read register (store / error responses)
//   rdata        registered read data
module dm_responder_bank #(
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr_en,
  input  logic [DEPTH_LOG2-1:0] clr_idx,
  input  logic                  wr_en,
  input  logic [3:0]            wr_be,
  input  logic [DEPTH_LOG2-1:0] idx,
  input  logic [31:0]           wdata,
  input  logic                  rd_en,
  input  logic                  rd_zero,
  output logic [31:0]           rdata
);
  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

  // One independent array per byte lane keeps each lane a plain
  // single-write-port RAM with its own enable.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] lane_mem [DEPTH];
    logic [7:0] lane_rd_reg;

    always_ff @(posedge clk) begin
      if (clr_en) begin
        lane_mem[clr_idx] <= 8'h00;
      end else if (wr_en && wr_be[gi]) begin
        lane_mem[idx] <= wdata[8*gi +: 8];
      end
    end

    always_ff @(posedge clk) begin
      if (!reset) begin
        lane_rd_reg <= 8'h00;
      end else if (rd_en) begin
        lane_rd_reg <= lane_mem[idx];
      end else if (rd_zero) begin
        lane_rd_reg <= 8'h00;
      end
    end

    assign rdata[8*gi +: 8] = lane_rd_reg;
  end
endmodule

// File: rtl/dm_responder.sv
// Memory-side responder with programmable wait states. Accepts one word
// request at a time, waits LATENCY cycles, then returns load data or a
// store acknowledge. After reset the whole array is swept to zero before
// the first request is accepted.
// Ports:
//   clk    single clock
//   reset  synchronous active-low reset
//   bus    dm_responder_if.slave request/response bus
module dm_responder
  import dm_responder_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = DMR_DEPTH_LOG2,
  parameter int unsigned LATENCY    = DMR_LATENCY
) (
  input  logic          clk,
  input  logic          reset,
  dm_responder_if.slave bus
);
  dmr_state_t            state_reg;
  logic [DEPTH_LOG2-1:0] clr_idx_reg;
  logic [3:0]            cnt_reg;
  logic                  we_reg;
  logic [29:0]           word_reg;
  logic [3:0]            be_reg;
  logic [31:0]           wdata_reg;
  logic                  resp_valid_reg;
  logic                  resp_err_reg;

  logic                  accept;
  logic                  enter_resp;
  logic                  act_we;
  logic [29:0]           act_word;
  logic [3:0]            act_be;
  logic [31:0]           act_wdata;
  logic                  act_err;
  logic [31:0]           bank_rdata;
  logic                  unused_addr_bits;

  // Byte offset within the word has no effect on a word access.
  assign unused_addr_bits = &{1'b0, bus.req_addr[1:0]};

  assign accept = (state_reg == ST_IDLE) && bus.req_valid;

  // With LATENCY==1 the memory action happens on the accept edge itself, so
  // the request fields come straight from the bus; otherwise from the latch.
  assign act_we    = (state_reg == ST_IDLE) ? bus.req_we          : we_reg;
  assign act_word  = (state_reg == ST_IDLE) ? bus.req_addr[31:2]  : word_reg;
  assign act_be    = (state_reg == ST_IDLE) ? bus.req_be          : be_reg;
  assign act_wdata = (state_reg == ST_IDLE) ? bus.req_wdata       : wdata_reg;
  assign act_err   = word_out_of_range(act_word, DEPTH_LOG2);

  // Gated by reset so that a transaction in flight when reset arrives never
  // touches the array.
  assign enter_resp = reset &&
                      ((accept && (LATENCY == 1)) ||
                       ((state_reg == ST_WAIT) && (cnt_reg == 4'd1)));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg      <= ST_CLEAR;
      clr_idx_reg    <= '0;
      cnt_reg        <= 4'd0;
      we_reg         <= 1'b0;
      word_reg       <= 30'd0;
      be_reg         <= 4'd0;
      wdata_reg      <= 32'd0;
      resp_valid_reg <= 1'b0;
      resp_err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ST_CLEAR: begin
          clr_idx_reg <= clr_idx_reg + 1'b1;
          if (clr_idx_reg == '1) begin
            state_reg <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (bus.req_valid) begin
            we_reg    <= bus.req_we;
            word_reg  <= bus.req_addr[31:2];
            be_reg    <= bus.req_be;
            wdata_reg <= bus.req_wdata;
            cnt_reg   <= 4'(LATENCY - 1);
            if (LATENCY == 1) begin
              state_reg      <= ST_RESP;
              resp_valid_reg <= 1'b1;
              resp_err_reg   <= act_err;
            end else begin
              state_reg <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          cnt_reg <= cnt_reg - 4'd1;
          if (cnt_reg == 4'd1) begin
            state_reg      <= ST_RESP;
            resp_valid_reg <= 1'b1;
            resp_err_reg   <= act_err;
          end
        end
        ST_RESP: begin
          // Returning to IDLE costs one bubble before the next accept.
          if (bus.resp_ready) begin
            state_reg      <= ST_IDLE;
            resp_valid_reg <= 1'b0;
          end
        end
        default: state_reg <= ST_CLEAR;
      endcase
    end
  end

  dm_responder_bank #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_bank (
    .clk     (clk),
    .reset   (reset),
    .clr_en  (reset && (state_reg == ST_CLEAR)),
    .clr_idx (clr_idx_reg),
    .wr_en   (enter_resp && act_we && !act_err),
    .wr_be   (act_be),
    .idx     (act_word[DEPTH_LOG2-1:0]),
    .wdata   (act_wdata),
    .rd_en   (enter_resp && !act_we && !act_err),
    .rd_zero (enter_resp && (act_we || act_err)),
    .rdata   (bank_rdata)
  );

  assign bus.req_ready  = (state_reg == ST_IDLE);
  assign bus.resp_valid = resp_valid_reg;
  assign bus.resp_rdata = bank_rdata;
  assign bus.resp_err   = resp_err_reg;
endmodule
